// File: rtl/aes_pkg.sv
// Shared AES controller definitions: block geometry, FSM encoding, round count.
// No logic of its own; widths here are used by every controller instance.
// Changing BLK_W or CNT_W affects all ports derived from them.
package aes_pkg;

   // One AES block and its shape in 32-bit columns
   localparam int BLK_W = 128;
   localparam int NB    = 4;

   // Round counter width; covers NR up to 14 without wrap
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   // Round count for a key of nk 32-bit words (10/12/14 for 4/6/8)
   function automatic int nr_from_nk(input int nk);
      return nk + 6;
   endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer driving an external round unit and key store.
// Latency: result valid NR+1 cycles after the accept cycle; one block in flight.
// Backpressure: in_ready low while busy; DONE holds out_data until out_ready.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NK = 4,
   parameter int NR = nr_from_nk(NK)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   output logic [3:0]       key_idx,
   input  logic [BLK_W-1:0] round_key,
   output logic [BLK_W-1:0] rnd_state,
   output logic             rnd_final,
   input  logic [BLK_W-1:0] rnd_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   input  logic             flush,
   output logic             busy
);

   // Last round index in counter width; NR must stay within 4 bits
   localparam logic [CNT_W-1:0] NR_C = CNT_W'(NR);

   fsm_t             fsm;
   logic [CNT_W-1:0] cnt;
   logic [BLK_W-1:0] state;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   // Sequencer: whitening on accept, one round per RUN cycle, hold in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= ST_IDLE;
         cnt         <= '0;
         state       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (flush) begin
         fsm         <= ST_IDLE;
         cnt         <= '0;
         state       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (in_valid) begin
                  // key_idx is 0 here, so round_key is the whitening key
                  state      <= in_data ^ round_key;
                  cnt        <= 4'd1;
                  fsm        <= ST_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_RUN: begin
               state <= rnd_result;
               if (cnt == NR_C) begin
                  fsm         <= ST_DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_DONE: begin
               // in_ready stays low this cycle, so no new block slips in
               if (out_ready) begin
                  fsm         <= ST_IDLE;
                  cnt         <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               fsm         <= ST_IDLE;
               cnt         <= '0;
               state       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // Round-unit and key-store outputs are decoded from registers only
   assign key_idx   = (fsm == ST_RUN) ? cnt : 4'd0;
   assign rnd_state = (fsm == ST_RUN) ? state : '0;
   assign rnd_final = (fsm == ST_RUN) && (cnt == NR_C);

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = out_valid_q ? state : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with behavioural AES-128/AES-256 round unit and key store.
// Expected blocks go into a scoreboard queue at accept and are popped at out_valid.
// Two instances (NK=4 and NK=8) share the stimulus; cur_sel picks the active one.
module tb_aes_round_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid;
   logic [127:0] in_data;
   logic         out_ready;
   logic         flush;
   logic         cur_sel;

   logic         in_valid4, out_ready4, flush4, in_ready4, rnd_final4, out_valid4, busy4;
   logic [3:0]   key_idx4;
   logic [127:0] round_key4, rnd_state4, rnd_result4, out_data4;
   logic         in_valid8, out_ready8, flush8, in_ready8, rnd_final8, out_valid8, busy8;
   logic [3:0]   key_idx8;
   logic [127:0] round_key8, rnd_state8, rnd_result8, out_data8;

   logic [7:0]   sbox [256];
   logic [127:0] ek4 [15];
   logic [127:0] ek8 [15];
   logic [127:0] sb [$];

   int n_vec = 0;
   int n_err = 0;

   localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KAT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KAT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   // ---------------- reference AES (byte 0 at bits 127:120) ----------------
   function automatic logic [127:0] rev(input logic [127:0] x);
      logic [127:0] r;
      for (int i = 0; i < 128; i++) r[i] = x[127-i];
      return r;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic logic [127:0] rk_of(input logic [255:0] key, input int nk, input int idx);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk, input logic fin);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   s0, s1, s2, s3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sbox[st[127-8*i -: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
      if (!fin) begin
         for (int c = 0; c < 4; c++) begin
            s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
            b[4*c]   = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
            b[4*c+1] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
            b[4*c+2] = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
            b[4*c+3] = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
      return o ^ rk;
   endfunction

   function automatic logic [127:0] aes128_enc(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ ek4[0];
      for (int r = 1; r <= 10; r++) s = aes_round(s, ek4[r], r == 10);
      return s;
   endfunction

   // ---------------- external key stores and round units ----------------
   assign round_key4  = rev(ek4[key_idx4]);
   assign rnd_result4 = rev(aes_round(rev(rnd_state4), ek4[key_idx4], rnd_final4));
   assign round_key8  = rev(ek8[key_idx8]);
   assign rnd_result8 = rev(aes_round(rev(rnd_state8), ek8[key_idx8], rnd_final8));

   assign in_valid4  = in_valid  & ~cur_sel;
   assign out_ready4 = out_ready & ~cur_sel;
   assign flush4     = flush     & ~cur_sel;
   assign in_valid8  = in_valid  &  cur_sel;
   assign out_ready8 = out_ready &  cur_sel;
   assign flush8     = flush     &  cur_sel;

   logic         o_in_ready, o_rnd_final, o_out_valid, o_busy;
   logic [3:0]   o_key_idx;
   logic [127:0] o_rnd_state, o_out_data;
   assign o_in_ready  = cur_sel ? in_ready8  : in_ready4;
   assign o_rnd_final = cur_sel ? rnd_final8 : rnd_final4;
   assign o_out_valid = cur_sel ? out_valid8 : out_valid4;
   assign o_busy      = cur_sel ? busy8      : busy4;
   assign o_key_idx   = cur_sel ? key_idx8   : key_idx4;
   assign o_rnd_state = cur_sel ? rnd_state8 : rnd_state4;
   assign o_out_data  = cur_sel ? out_data8  : out_data4;

   aes_round_ctrl #(.NK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_data(in_data), .key_idx(key_idx4), .round_key(round_key4),
      .rnd_state(rnd_state4), .rnd_final(rnd_final4), .rnd_result(rnd_result4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .flush(flush4), .busy(busy4)
   );

   aes_round_ctrl #(.NK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data), .key_idx(key_idx8), .round_key(round_key8),
      .rnd_state(rnd_state8), .rnd_final(rnd_final8), .rnd_result(rnd_result8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .flush(flush8), .busy(busy8)
   );

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_in_ready"},  128'(o_in_ready), 128'd1);
      chk({tag, "_busy"},      128'(o_busy), 128'd0);
      chk({tag, "_out_valid"}, 128'(o_out_valid), 128'd0);
      chk({tag, "_key_idx"},   128'(o_key_idx), 128'd0);
      chk({tag, "_rnd_state"}, o_rnd_state, 128'd0);
      chk({tag, "_rnd_final"}, 128'(o_rnd_final), 128'd0);
      chk({tag, "_out_data"},  o_out_data, 128'd0);
   endtask

   task automatic quiet(input int n, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (o_out_valid) seen++;
      end
      chk(tag, 128'(seen), 128'd0);
   endtask

   // Offer one block at the current (idle) negedge and follow it to completion
   task automatic run_block(input logic [127:0] pt, input logic [127:0] exp,
                            input int lat_exp, input int hold, input bit spam);
      int           lat;
      logic [127:0] held;
      logic [127:0] want;
      chk("in_ready_idle", 128'(o_in_ready), 128'd1);
      chk("key_idx_idle", 128'(o_key_idx), 128'd0);
      in_valid = 1'b1;
      in_data  = rev(pt);
      sb.push_back(exp);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         in_valid = spam;
         in_data  = rev(~pt);
         if (!o_out_valid) begin
            chk("key_idx_run", 128'(o_key_idx), 128'(lat));
            chk("rnd_final_run", 128'(o_rnd_final), 128'(lat == lat_exp - 1));
            chk("in_ready_run", 128'(o_in_ready), 128'd0);
         end
      end while (!o_out_valid && lat < 60);
      chk("latency", 128'(lat), 128'(lat_exp));
      held = o_out_data;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("out_data_hold", o_out_data, held);
         chk("out_valid_hold", 128'(o_out_valid), 128'd1);
         chk("in_ready_done", 128'(o_in_ready), 128'd0);
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 128'(sb.size()), 128'd1);
      end else begin
         want = sb.pop_front();
         chk("out_data", o_out_data, rev(want));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("in_ready_after", 128'(o_in_ready), 128'd1);
      chk("out_valid_after", 128'(o_out_valid), 128'd0);
      chk("busy_after", 128'(o_busy), 128'd0);
   endtask

   // Accept a block, then step until the round counter reaches target
   task automatic start_and_reach(input logic [127:0] pt, input int target, input string tag);
      int guard;
      in_valid = 1'b1;
      in_data  = rev(pt);
      sb.push_back(aes128_enc(pt));
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (o_key_idx != 4'(target) && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      chk(tag, 128'(o_key_idx), 128'(target));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0]   inv;
      logic [127:0] pt;

      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      for (int i = 0; i < 15; i++) begin
         ek4[i] = (i <= 10) ? rk_of(KEY_128, 4, i) : 128'h0;
         ek8[i] = rk_of(KEY_256, 8, i);
      end

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      flush = 1'b0; cur_sel = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset4");
      cur_sel = 1'b1; #1;
      check_idle_outputs("reset8");
      cur_sel = 1'b0; #1;
      rst_n = 1'b1;
      @(negedge clk);

      // AES-128 known answer, result held 5 cycles, in_valid kept high throughout
      run_block(KAT_PT, KAT_128, 11, 5, 1'b1);
      quiet(5, "single_block_only");

      // Further blocks checked against the reference cipher
      for (int n = 0; n < 2; n++) begin
         pt = {$urandom, $urandom, $urandom, $urandom};
         run_block(pt, aes128_enc(pt), 11, n, 1'b0);
      end

      // Flush in the middle of a run
      start_and_reach(128'hdeadbeef_00000000_cafef00d_12345678, 5, "flush_reach_cnt5");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_idle_outputs("flush");
      void'(sb.pop_back());
      quiet(15, "flush_no_out_valid");
      pt = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      run_block(pt, aes128_enc(pt), 11, 0, 1'b0);

      // Asynchronous reset in the middle of a run
      start_and_reach(128'h11111111_22222222_33333333_44444444, 3, "reset_reach_cnt3");
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      void'(sb.pop_back());
      quiet(15, "reset_no_out_valid");
      pt = KAT_PT;
      run_block(pt, KAT_128, 11, 0, 1'b0);

      // AES-256 known answer on the NK=8 instance
      cur_sel = 1'b1; #1;
      run_block(KAT_PT, KAT_256, 15, 2, 1'b0);

      chk("scoreboard_drained", 128'(sb.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
